// File: rtl/tlb_walk_ctrl_if.sv
// Bus bundle between the Sv39 page-table walker and its environment.
//   IF/MA miss ports : *_miss, *_vpn in; *_done, *_fault pulses out
//   root / flush     : satp_ppn, sfence in
//   TLB refill side  : tlb_invalid, tlb_if_update, tlb_ma_update, tlb_wdata out
//   PTE read port    : mem_req, mem_addr out; mem_ack, mem_rdata in
//   status           : busy out
// The walker connects through modport slave; the requesting side through master.
interface tlb_walk_ctrl_if #(
   parameter int PA_W = 56
) ();
   logic             if_miss;
   logic [26:0]      if_vpn;
   logic             if_done;
   logic             if_fault;
   logic             ma_miss;
   logic [26:0]      ma_vpn;
   logic             ma_done;
   logic             ma_fault;
   logic [43:0]      satp_ppn;
   logic             sfence;
   logic             tlb_invalid;
   logic             tlb_if_update;
   logic             tlb_ma_update;
   logic [43:0]      tlb_wdata;
   logic             mem_req;
   logic [PA_W-1:0]  mem_addr;
   logic             mem_ack;
   logic [63:0]      mem_rdata;
   logic             busy;

   modport slave (
      input  if_miss, if_vpn, ma_miss, ma_vpn, satp_ppn, sfence, mem_ack, mem_rdata,
      output if_done, if_fault, ma_done, ma_fault, tlb_invalid, tlb_if_update,
             tlb_ma_update, tlb_wdata, mem_req, mem_addr, busy
   );

   modport master (
      output if_miss, if_vpn, ma_miss, ma_vpn, satp_ppn, sfence, mem_ack, mem_rdata,
      input  if_done, if_fault, ma_done, ma_fault, tlb_invalid, tlb_if_update,
             tlb_ma_update, tlb_wdata, mem_req, mem_addr, busy
   );
endinterface

// File: rtl/tlb_walk_ctrl.sv
// Sv39 page-table walker / refill controller for the dual-port (IF, MA) TLB.
// Arbitrates IF and MA misses round-robin, walks the page table through one
// PTE read port, writes the leaf PPN back through the matching TLB update
// strobe and sequences sfence flushes so they never race a refill.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : tlb_walk_ctrl_if.slave (miss ports, TLB refill, PTE memory, busy)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting; flush has priority over granting a miss
// S_REQ    | PTE read outstanding for the current level
// S_CHECK  | decode latched PTE: descend, refill, or fault
// S_RETIRE | one quiet cycle so the requester can drop its miss
// S_FLUSH  | one-cycle tlb_invalid pulse
module tlb_walk_ctrl #(
   parameter int PA_W   = 56,
   parameter int LEVELS = 3
) (
   input logic            clk,
   input logic            rst,
   tlb_walk_ctrl_if.slave bus
);

   localparam logic [1:0] TOP_LEVEL = 2'(LEVELS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_CHECK,
      S_RETIRE,
      S_FLUSH
   } state_t;

   state_t      r_state,      w_state_nxt;
   logic [1:0]  r_level,      w_level_nxt;
   logic        r_last_ma,    w_last_ma_nxt;
   logic        r_flush_pend, w_flush_pend_nxt;
   logic        r_port_ma,    w_port_ma_nxt;
   logic [26:0] r_vpn,        w_vpn_nxt;
   logic [43:0] r_ppn_cur,    w_ppn_cur_nxt;
   logic [43:0] r_pte_ppn,    w_pte_ppn_nxt;
   logic [3:0]  r_pte_flags,  w_pte_flags_nxt;

   logic        w_grant_ma;
   logic        w_mem_req;
   logic        w_done;
   logic        w_fault;
   logic        w_update;
   logic        w_invalid;
   logic [8:0]  w_vpn_idx;
   logic [55:0] w_addr_full;
   logic        w_pte_v;
   logic        w_pte_r;
   logic        w_pte_w;
   logic        w_pte_x;
   logic        w_nonleaf;
   logic        w_misalign;
   logic        w_bad;
   logic [43:0] w_leaf_wdata;

   // VPN slice indexing the table at the current level
   always_comb begin
      w_vpn_idx = r_vpn[8:0];
      case (r_level)
         2'd2:    w_vpn_idx = r_vpn[26:18];
         2'd1:    w_vpn_idx = r_vpn[17:9];
         default: w_vpn_idx = r_vpn[8:0];
      endcase
   end

   assign w_addr_full = {r_ppn_cur, w_vpn_idx, 3'b000};

   assign w_pte_v   = r_pte_flags[0];
   assign w_pte_r   = r_pte_flags[1];
   assign w_pte_w   = r_pte_flags[2];
   assign w_pte_x   = r_pte_flags[3];
   assign w_nonleaf = ~w_pte_r & ~w_pte_x;

   // Superpage leaves splice the untranslated VPN bits into the low PPN bits;
   // those PPN bits must be zero or the mapping is misaligned.
   always_comb begin
      w_misalign   = 1'b0;
      w_leaf_wdata = r_pte_ppn;
      case (r_level)
         2'd2: begin
            w_misalign   = |r_pte_ppn[17:0];
            w_leaf_wdata = {r_pte_ppn[43:18], r_vpn[17:0]};
         end
         2'd1: begin
            w_misalign   = |r_pte_ppn[8:0];
            w_leaf_wdata = {r_pte_ppn[43:9], r_vpn[8:0]};
         end
         default: begin
            w_misalign   = 1'b0;
            w_leaf_wdata = r_pte_ppn;
         end
      endcase
   end

   assign w_bad = ~w_pte_v
                | (~w_pte_r & w_pte_w)
                | (w_nonleaf & (r_level == 2'd0))
                | (~w_nonleaf & w_misalign);

   always_comb begin
      w_state_nxt     = r_state;
      w_level_nxt     = r_level;
      w_last_ma_nxt   = r_last_ma;
      w_port_ma_nxt   = r_port_ma;
      w_vpn_nxt       = r_vpn;
      w_ppn_cur_nxt   = r_ppn_cur;
      w_pte_ppn_nxt   = r_pte_ppn;
      w_pte_flags_nxt = r_pte_flags;
      w_grant_ma      = 1'b0;
      w_mem_req       = 1'b0;
      w_done          = 1'b0;
      w_fault         = 1'b0;
      w_update        = 1'b0;
      w_invalid       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (r_flush_pend || bus.sfence) begin
               w_state_nxt = S_FLUSH;
            end else if (bus.if_miss || bus.ma_miss) begin
               // On a tie the port that was not served last wins.
               w_grant_ma    = bus.ma_miss && (!bus.if_miss || !r_last_ma);
               w_port_ma_nxt = w_grant_ma;
               w_last_ma_nxt = w_grant_ma;
               w_vpn_nxt     = w_grant_ma ? bus.ma_vpn : bus.if_vpn;
               w_ppn_cur_nxt = bus.satp_ppn;
               w_level_nxt   = TOP_LEVEL;
               w_state_nxt   = S_REQ;
            end
         end
         S_REQ: begin
            w_mem_req = 1'b1;
            if (bus.mem_ack) begin
               w_pte_ppn_nxt   = bus.mem_rdata[53:10];
               w_pte_flags_nxt = bus.mem_rdata[3:0];
               w_state_nxt     = S_CHECK;
            end
         end
         S_CHECK: begin
            if (w_bad) begin
               w_fault     = 1'b1;
               w_state_nxt = S_RETIRE;
            end else if (w_nonleaf) begin
               w_ppn_cur_nxt = r_pte_ppn;
               w_level_nxt   = r_level - 2'd1;
               w_state_nxt   = S_REQ;
            end else begin
               // A pending flush would wipe this entry anyway; skip the write
               // and let the requester re-miss after the flush.
               w_done      = 1'b1;
               w_update    = ~r_flush_pend;
               w_state_nxt = S_RETIRE;
            end
         end
         S_RETIRE: begin
            w_state_nxt = S_IDLE;
         end
         S_FLUSH: begin
            w_invalid   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // A sfence arriving during FLUSH re-arms the pending flag so it is not lost.
   always_comb begin
      w_flush_pend_nxt = (r_state == S_FLUSH) ? 1'b0 : r_flush_pend;
      if (bus.sfence && (r_state != S_IDLE)) begin
         w_flush_pend_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_level      <= TOP_LEVEL;
         r_last_ma    <= 1'b1;
         r_flush_pend <= 1'b0;
         r_port_ma    <= 1'b0;
         r_vpn        <= '0;
         r_ppn_cur    <= '0;
         r_pte_ppn    <= '0;
         r_pte_flags  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_level      <= w_level_nxt;
         r_last_ma    <= w_last_ma_nxt;
         r_flush_pend <= w_flush_pend_nxt;
         r_port_ma    <= w_port_ma_nxt;
         r_vpn        <= w_vpn_nxt;
         r_ppn_cur    <= w_ppn_cur_nxt;
         r_pte_ppn    <= w_pte_ppn_nxt;
         r_pte_flags  <= w_pte_flags_nxt;
      end
   end

   assign bus.if_done       = w_done  & ~r_port_ma;
   assign bus.ma_done       = w_done  &  r_port_ma;
   assign bus.if_fault      = w_fault & ~r_port_ma;
   assign bus.ma_fault      = w_fault &  r_port_ma;
   assign bus.tlb_if_update = w_update & ~r_port_ma;
   assign bus.tlb_ma_update = w_update &  r_port_ma;
   assign bus.tlb_wdata     = w_update ? w_leaf_wdata : 44'd0;
   assign bus.tlb_invalid   = w_invalid;
   assign bus.mem_req       = w_mem_req;
   assign bus.mem_addr      = w_mem_req ? PA_W'(w_addr_full) : '0;
   assign bus.busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_tlb_walk_ctrl.sv
module tb_tlb_walk_ctrl;

   logic clk;
   logic rst;

   tlb_walk_ctrl_if #(.PA_W(56)) bus ();

   tlb_walk_ctrl #(.PA_W(56), .LEVELS(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        port_ma;
      logic        fault;
      logic        upd;
      logic [43:0] wdata;
   } res_t;

   int          checks;
   int          failures;
   bit          resp_en;
   res_t        q_res[$];
   logic [55:0] q_addr[$];
   logic [63:0] mem [logic [55:0]];

   localparam logic [26:0] VPN3 = {9'h004, 9'h001, 9'h003};

   function automatic logic [55:0] pa(input logic [43:0] ppn, input logic [8:0] idx);
      return {ppn, idx, 3'b000};
   endfunction

   // flags: X=b3 R=b1 set for leaves, V=b0
   function automatic logic [63:0] pte(input logic [43:0] ppn, input logic leaf, input logic valid);
      return {10'd0, ppn, 6'd0, leaf, 1'b0, leaf, valid};
   endfunction

   function automatic res_t mk(input logic p, input logic f, input logic u, input logic [43:0] w);
      res_t r;
      r.port_ma = p; r.fault = f; r.upd = u; r.wdata = w;
      return r;
   endfunction

   // PTE memory: single-cycle ack while enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (resp_en) begin
            bus.mem_ack   = bus.mem_req;
            bus.mem_rdata = (bus.mem_req && mem.exists(bus.mem_addr)) ? mem[bus.mem_addr] : 64'd0;
         end
      end
   end

   // Scoreboard monitor
   res_t        m_e;
   logic [49:0] m_obs;
   logic [49:0] m_exp;
   logic [55:0] m_a;
   initial begin
      forever begin
         @(negedge clk);
         if (bus.mem_req && bus.mem_ack) begin
            checks++;
            if (q_addr.size() == 0) begin
               failures++;
               $display("FAIL mem_addr_unexpected got=%h", bus.mem_addr);
            end else begin
               m_a = q_addr.pop_front();
               if (bus.mem_addr !== m_a) begin
                  failures++;
                  $display("FAIL mem_addr got=%h exp=%h", bus.mem_addr, m_a);
               end
            end
         end
         if (bus.if_done | bus.if_fault | bus.ma_done | bus.ma_fault |
             bus.tlb_if_update | bus.tlb_ma_update) begin
            checks++;
            m_obs = {bus.if_done, bus.if_fault, bus.ma_done, bus.ma_fault,
                     bus.tlb_if_update, bus.tlb_ma_update, bus.tlb_wdata};
            if (q_res.size() == 0) begin
               failures++;
               $display("FAIL result_unexpected got=%h", m_obs);
            end else begin
               m_e = q_res.pop_front();
               m_exp = {~m_e.port_ma & ~m_e.fault, ~m_e.port_ma & m_e.fault,
                        m_e.port_ma & ~m_e.fault, m_e.port_ma & m_e.fault,
                        m_e.upd & ~m_e.port_ma, m_e.upd & m_e.port_ma,
                        m_e.upd ? m_e.wdata : 44'd0};
               if (m_obs !== m_exp) begin
                  failures++;
                  $display("FAIL result got=%h exp=%h", m_obs, m_exp);
               end
            end
         end
         if (bus.tlb_if_update | bus.tlb_ma_update | bus.tlb_invalid) begin
            checks++;
            if ((bus.tlb_if_update & bus.tlb_ma_update) |
                ((bus.tlb_if_update | bus.tlb_ma_update) & bus.tlb_invalid)) begin
               failures++;
               $display("FAIL strobe_exclusive got if_upd=%b ma_upd=%b inv=%b exp at most one",
                        bus.tlb_if_update, bus.tlb_ma_update, bus.tlb_invalid);
            end
         end
      end
   end

   // Raise the selected misses, drop each in its RETIRE cycle; return the
   // cycle (1 = raise cycle) in which each port saw done/fault.
   task automatic serve(input bit do_if, input bit do_ma, output int cyc_if, output int cyc_ma);
      bit pend_if, pend_ma, drop_if, drop_ma;
      int n;
      cyc_if = 0; cyc_ma = 0; n = 0;
      @(posedge clk); #1;
      bus.if_miss = do_if; bus.ma_miss = do_ma;
      pend_if = do_if; pend_ma = do_ma;
      while ((pend_if || pend_ma) && n < 200) begin
         @(negedge clk);
         n++;
         drop_if = bus.if_done | bus.if_fault;
         drop_ma = bus.ma_done | bus.ma_fault;
         if (drop_if) begin cyc_if = n; pend_if = 0; end
         if (drop_ma) begin cyc_ma = n; pend_ma = 0; end
         @(posedge clk); #1;
         if (drop_if) bus.if_miss = 1'b0;
         if (drop_ma) bus.ma_miss = 1'b0;
      end
      checks++;
      if (pend_if || pend_ma) begin
         failures++;
         $display("FAIL serve_timeout got pend_if=%b pend_ma=%b exp 0", pend_if, pend_ma);
         bus.if_miss = 1'b0; bus.ma_miss = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [108:0] v;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      v = {bus.if_done, bus.if_fault, bus.ma_done, bus.ma_fault, bus.tlb_invalid,
           bus.tlb_if_update, bus.tlb_ma_update, bus.tlb_wdata, bus.mem_req, bus.mem_addr, bus.busy};
      checks++;
      if (v !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", v);
      end
   endtask

   task automatic test_simultaneous();
      int ci, cm;
      logic [26:0] vi, vm;
      vi = {9'h010, 9'h0AA, 9'h055};
      vm = {9'h020, 9'h0BB, 9'h066};
      bus.if_vpn = vi; bus.ma_vpn = vm;
      mem[pa(44'h100, 9'h010)] = pte(44'h1C0000, 1'b1, 1'b1);
      mem[pa(44'h100, 9'h020)] = pte(44'h2C0000, 1'b1, 1'b1);
      // round A: first tie after reset goes to IF
      q_addr.push_back(pa(44'h100, 9'h010)); q_res.push_back(mk(0, 0, 1, 44'h1D5455));
      q_addr.push_back(pa(44'h100, 9'h020)); q_res.push_back(mk(1, 0, 1, 44'h2D7666));
      serve(1, 1, ci, cm);
      checks++;
      if (ci != 3 || cm != 7) begin
         failures++;
         $display("FAIL tie_if_first got if=%0d ma=%0d exp if=3 ma=7", ci, cm);
      end
      // round B: IF alone
      q_addr.push_back(pa(44'h100, 9'h010)); q_res.push_back(mk(0, 0, 1, 44'h1D5455));
      serve(1, 0, ci, cm);
      // round C: tie after IF was last -> MA first
      q_addr.push_back(pa(44'h100, 9'h020)); q_res.push_back(mk(1, 0, 1, 44'h2D7666));
      q_addr.push_back(pa(44'h100, 9'h010)); q_res.push_back(mk(0, 0, 1, 44'h1D5455));
      serve(1, 1, ci, cm);
      checks++;
      if (cm != 3 || ci != 7) begin
         failures++;
         $display("FAIL tie_ma_first got if=%0d ma=%0d exp if=7 ma=3", ci, cm);
      end
   endtask

   task automatic test_three_level();
      int ci, cm;
      bus.if_vpn = VPN3;
      mem[pa(44'h100, 9'h004)] = pte(44'h200, 1'b0, 1'b1);
      mem[pa(44'h200, 9'h001)] = pte(44'h300, 1'b0, 1'b1);
      mem[pa(44'h300, 9'h003)] = pte(44'hABCDE, 1'b1, 1'b1);
      q_addr.push_back(56'h100020);
      q_addr.push_back(56'h200008);
      q_addr.push_back(56'h300018);
      q_res.push_back(mk(0, 0, 1, 44'hABCDE));
      serve(1, 0, ci, cm);
      checks++;
      if (ci != 7) begin
         failures++;
         $display("FAIL walk_latency got=%0d exp=7", ci);
      end
   endtask

   task automatic test_fault();
      int ci, cm;
      bus.ma_vpn = {9'h030, 9'h011, 9'h022};
      mem[pa(44'h100, 9'h030)] = pte(44'h500, 1'b0, 1'b1);
      mem[pa(44'h500, 9'h011)] = 64'd0;
      q_addr.push_back(pa(44'h100, 9'h030));
      q_addr.push_back(pa(44'h500, 9'h011));
      q_res.push_back(mk(1, 1, 0, 44'd0));
      serve(0, 1, ci, cm);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL fault_retire_busy got=%b exp=1", bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL fault_idle_busy got=%b exp=0", bus.busy);
      end
      // non-leaf at level 0
      bus.if_vpn = {9'h040, 9'h012, 9'h034};
      mem[pa(44'h100, 9'h040)] = pte(44'h510, 1'b0, 1'b1);
      mem[pa(44'h510, 9'h012)] = pte(44'h520, 1'b0, 1'b1);
      mem[pa(44'h520, 9'h034)] = pte(44'h530, 1'b0, 1'b1);
      q_addr.push_back(pa(44'h100, 9'h040));
      q_addr.push_back(pa(44'h510, 9'h012));
      q_addr.push_back(pa(44'h520, 9'h034));
      q_res.push_back(mk(0, 1, 0, 44'd0));
      serve(1, 0, ci, cm);
   endtask

   task automatic test_superpage();
      int ci, cm;
      bus.if_vpn = {9'h050, 9'h013, 9'h1F5};
      mem[pa(44'h100, 9'h050)] = pte(44'h600, 1'b0, 1'b1);
      mem[pa(44'h600, 9'h013)] = pte(44'h40000200, 1'b1, 1'b1);
      q_addr.push_back(pa(44'h100, 9'h050));
      q_addr.push_back(pa(44'h600, 9'h013));
      q_res.push_back(mk(0, 0, 1, 44'h400003F5));
      serve(1, 0, ci, cm);
      mem[pa(44'h600, 9'h013)] = pte(44'h40000201, 1'b1, 1'b1);
      q_addr.push_back(pa(44'h100, 9'h050));
      q_addr.push_back(pa(44'h600, 9'h013));
      q_res.push_back(mk(0, 1, 0, 44'd0));
      serve(1, 0, ci, cm);
   endtask

   task automatic test_sfence();
      bit found, got, saw_req;
      // sfence while idle
      @(posedge clk); #1 bus.sfence = 1'b1;
      @(posedge clk); #1 bus.sfence = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.tlb_invalid !== 1'b1) begin
         failures++;
         $display("FAIL idle_sfence_invalid got=%b exp=1", bus.tlb_invalid);
      end
      // sfence and miss together: flush wins
      @(posedge clk); #1 bus.sfence = 1'b1; bus.if_vpn = VPN3; bus.if_miss = 1'b1;
      @(posedge clk); #1 bus.sfence = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.tlb_invalid, bus.mem_req} !== 2'b10) begin
         failures++;
         $display("FAIL sfence_priority got inv,req=%b exp=10", {bus.tlb_invalid, bus.mem_req});
      end
      @(posedge clk); #1 bus.if_miss = 1'b0;
      @(posedge clk);
      // sfence during level-1 REQ
      q_addr.push_back(56'h100020); q_addr.push_back(56'h200008); q_addr.push_back(56'h300018);
      q_res.push_back(mk(0, 0, 0, 44'd0));
      #1 bus.if_miss = 1'b1;
      found = 0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         if (bus.mem_req && bus.mem_addr == 56'h200008) found = 1;
      end
      bus.sfence = found;
      @(posedge clk); #1 bus.sfence = 1'b0;
      found = 0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         if (bus.if_done | bus.if_fault) found = 1;
      end
      @(posedge clk); #1 bus.if_miss = 1'b0;
      @(negedge clk);
      // requester re-misses; the flush must come before any new grant
      @(posedge clk); #1;
      q_addr.push_back(56'h100020); q_addr.push_back(56'h200008); q_addr.push_back(56'h300018);
      q_res.push_back(mk(0, 0, 1, 44'hABCDE));
      bus.if_miss = 1'b1;
      got = 0; saw_req = 0;
      for (int k = 0; k < 5 && !got; k++) begin
         @(negedge clk);
         if (bus.mem_req) saw_req = 1;
         if (bus.tlb_invalid) got = 1;
      end
      checks++;
      if (!found || !got || saw_req) begin
         failures++;
         $display("FAIL midwalk_flush got done=%b inv=%b req_before=%b exp 1 1 0", found, got, saw_req);
      end
      found = 0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         if (bus.if_done | bus.if_fault) found = 1;
      end
      @(posedge clk); #1 bus.if_miss = 1'b0;
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL rewalk_timeout got=0 exp=1");
      end
      @(posedge clk);
   endtask

   task automatic test_reset_midwalk();
      logic [108:0] v;
      resp_en = 0;
      @(posedge clk); #1 bus.mem_ack = 1'b0; bus.if_vpn = VPN3; bus.if_miss = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b1; bus.if_miss = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.mem_req} !== 2'b11) begin
         failures++;
         $display("FAIL midwalk_in_req got busy,req=%b exp=11", {bus.busy, bus.mem_req});
      end
      @(posedge clk); #1 rst = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = pte(44'hABCDE, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         v = {bus.if_done, bus.if_fault, bus.ma_done, bus.ma_fault, bus.tlb_invalid,
              bus.tlb_if_update, bus.tlb_ma_update, bus.tlb_wdata, bus.mem_req, bus.mem_addr, bus.busy};
         checks++;
         if (v !== '0) begin
            failures++;
            $display("FAIL reset_midwalk_outputs cyc=%0d got=%h exp=0", k, v);
         end
         @(posedge clk); #1 bus.mem_ack = 1'b0; bus.mem_rdata = 64'd0;
      end
      resp_en = 1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      checks = 0; failures = 0; resp_en = 1;
      clk = 1'b0; rst = 1'b1;
      bus.if_miss = 1'b0; bus.if_vpn = '0; bus.ma_miss = 1'b0; bus.ma_vpn = '0;
      bus.satp_ppn = 44'h100; bus.sfence = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      test_reset();
      test_simultaneous();
      test_three_level();
      test_fault();
      test_superpage();
      test_sfence();
      test_reset_midwalk();
      repeat (3) @(negedge clk);
      checks++;
      if (q_res.size() != 0 || q_addr.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got res=%0d addr=%0d exp 0 0", q_res.size(), q_addr.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
